// File: rtl/spi_pkg.sv
// Shared SPI master definitions: mode encodings, FSM states, rate helpers.
package spi_pkg;

  localparam logic [1:0] MODE_RD     = 2'b00;
  localparam logic [1:0] MODE_WR     = 2'b01;
  localparam logic [1:0] MODE_CMD_RD = 2'b10;
  localparam logic [1:0] MODE_BAD    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_CLOCK,
    ST_TAIL,
    ST_RECOVER
  } spi_state_t;

  // sck period in clk cycles; below 4 the half periods collapse
  function automatic int spi_calc_n(input int clk_hz, input int rate);
    int q;
    q = clk_hz / rate;
    return (q < 4) ? 4 : q;
  endfunction

  function automatic logic [6:0] spi_clamp32(input logic [5:0] w);
    return (w > 6'd32) ? 7'd32 : {1'b0, w};
  endfunction

  function automatic logic [6:0] spi_nbits(
    input logic [1:0] mode,
    input logic [5:0] wr,
    input logic [5:0] rd
  );
    logic [6:0] n;
    n = '0;
    if (mode == MODE_RD)
      n = spi_clamp32(rd);
    else if (mode == MODE_WR)
      n = spi_clamp32(wr);
    else if (mode == MODE_CMD_RD)
      n = spi_clamp32(wr) + spi_clamp32(rd);
    return n;
  endfunction

endpackage

// File: rtl/spi_cs_sck_gen_half_tick.sv
// Half-period down counter; expire pulses one cycle before reload is due.
module spi_half_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= value;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));
  assign zero   = (cnt == '0);

endmodule

// File: rtl/spi_cs_sck_gen.sv
// SPI chip-select / serial-clock generator.
// Optional SPI_CS_GAP_EN adds cs_gap extra cycles of cs high time.
module spi_cs_sck_gen
  import spi_pkg::*;
#(
  parameter int system_clk = 50_000000,
  parameter int spi_rate   = 5_000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_sck_en,
  input  logic       cpol,
  input  logic [1:0] w_r_mode,
  input  logic [5:0] wr_width,
  input  logic [5:0] rd_width,
  output logic       cs,
  output logic       sck,
  output logic       busy,
  output logic       frame_done
`ifdef SPI_CS_GAP_EN
  ,
  input  logic [7:0] cs_gap
`endif
);

  localparam int N  = spi_calc_n(system_clk, spi_rate);
  localparam int HA = N / 2;
  localparam int HB = N - HA;
  localparam int CW = $clog2(N + 256) + 1;

  localparam logic [CW-1:0] HA_W  = CW'(HA);
  localparam logic [CW-1:0] HB_W  = CW'(HB);
  localparam logic [CW-1:0] REC_W = CW'(N - 1);

  spi_state_t  state_q, state_d;
  logic        en_q;
  logic        cs_q, sck_q, busy_q, done_q;
  logic        cpol_q;
  logic [6:0]  nbits_q;
  logic [6:0]  edge_q;
  logic        ld, start, tog, done;
  logic [CW-1:0] ld_val;
  logic [CW-1:0] rec_val;
  logic        expire, zero;
  logic        last;

`ifdef SPI_CS_GAP_EN
  logic [7:0] gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap_q <= '0;
    else if (start)
      gap_q <= cs_gap;
  end

  assign rec_val = REC_W + CW'(gap_q);
`else
  assign rec_val = REC_W;
`endif

  spi_half_tick #(.W(CW)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ld),
    .value  (ld_val),
    .expire (expire),
    .zero   (zero)
  );

  assign last = ({1'b0, edge_q} == ({nbits_q, 1'b0} - 8'd1));

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = HA_W;
    start   = 1'b0;
    tog     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_q && w_r_mode != MODE_BAD) begin
          start   = 1'b1;
          ld      = 1'b1;
          state_d = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (expire) begin
          ld = 1'b1;
          if (nbits_q == '0) begin
            state_d = ST_TAIL;
          end else begin
            tog     = 1'b1;
            ld_val  = HB_W;
            state_d = ST_CLOCK;
          end
        end
      end
      ST_CLOCK: begin
        if (expire) begin
          tog = 1'b1;
          ld  = 1'b1;
          // edge just made is edge_q+1; odd edges are followed by HB
          if (last)
            state_d = ST_TAIL;
          else
            ld_val = edge_q[0] ? HA_W : HB_W;
        end
      end
      ST_TAIL: begin
        if (expire) begin
          done    = 1'b1;
          ld      = 1'b1;
          ld_val  = rec_val;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if ((expire || zero) && !en_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= cs_sck_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b1;
      sck_q   <= cpol;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      nbits_q <= '0;
      edge_q  <= '0;
    end else begin
      cs_q   <= !(state_d inside {ST_LEAD, ST_CLOCK, ST_TAIL});
      busy_q <= (state_d != ST_IDLE);
      done_q <= done;
      if (start) begin
        cpol_q  <= cpol;
        nbits_q <= spi_nbits(w_r_mode, wr_width, rd_width);
      end
      if (state_q == ST_IDLE)
        edge_q <= '0;
      else if (tog && edge_q != 7'h7f)
        edge_q <= edge_q + 7'd1;
      if (state_q == ST_IDLE)
        sck_q <= cpol;
      else if (tog)
        sck_q <= ~sck_q;
      else if (state_q != ST_CLOCK)
        sck_q <= cpol_q;
    end
  end

  assign cs         = cs_q;
  assign sck        = sck_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_spi_cs_sck_gen.sv
// Directed bench for spi_cs_sck_gen at N=10 (HA=HB=5).
module tb_spi_cs_sck_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_sck_en;
  logic       cpol;
  logic [1:0] w_r_mode;
  logic [5:0] wr_width;
  logic [5:0] rd_width;
  logic       cs, sck, busy, frame_done;
`ifdef SPI_CS_GAP_EN
  logic [7:0] cs_gap;
`endif

  int errors = 0;
  int checks = 0;

  int fall_t, rise_t, fd_t, fd_n, nedg, busy_t;
  bit sck_at_fall, sck_at_rise, sck_e1;
  int et[160];

  spi_cs_sck_gen #(
    .system_clk (50_000000),
    .spi_rate   (5_000000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_sck_en  (cs_sck_en),
    .cpol       (cpol),
    .w_r_mode   (w_r_mode),
    .wr_width   (wr_width),
    .rd_width   (rd_width),
    .cs         (cs),
    .sck        (sck),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef SPI_CS_GAP_EN
    ,
    .cs_gap     (cs_gap)
`endif
  );

  always #5 clk = ~clk;

  task automatic settle(input int n);
    int g;
    g = 0;
    while (busy === 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    repeat (n) @(negedge clk);
  endtask

  // t counts edges after the one that first samples cs_sck_en (edge 0)
  task automatic capture(input int maxc, input bit drop, input bit scramble);
    logic prev;
    fall_t = -1; rise_t = -1; fd_t = -1; fd_n = 0; nedg = 0; busy_t = -1;
    sck_at_fall = 0; sck_at_rise = 0; sck_e1 = 0;
    prev = sck;
    for (int t = 0; t < maxc; t++) begin
      @(negedge clk);
      if (busy === 1'b1 && busy_t < 0) busy_t = t;
      if (busy === 1'b1 && drop) begin
        cs_sck_en = 1'b0;
        if (scramble) begin
          w_r_mode = 2'b11;
          wr_width = 6'd3;
        end
      end
      if (cs === 1'b0 && fall_t < 0) begin
        fall_t = t;
        sck_at_fall = sck;
      end
      if (sck !== prev && rise_t < 0) begin
        if (nedg == 0) sck_e1 = sck;
        if (nedg < 160) et[nedg] = t;
        nedg++;
      end
      prev = sck;
      if (frame_done === 1'b1) begin
        fd_n++;
        if (fd_t < 0) fd_t = t;
      end
      if (cs === 1'b1 && fall_t >= 0 && rise_t < 0) begin
        rise_t = t;
        sck_at_rise = sck;
      end
      if (rise_t >= 0 && t >= rise_t + 2) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cs_sck_en = 1'b0;
    cpol = 1'b1;
    w_r_mode = 2'b01;
    wr_width = 6'd8;
    rd_width = 6'd0;
`ifdef SPI_CS_GAP_EN
    cs_gap = 8'd0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs got=%b want=1", cs); end
    checks++;
    if (sck !== 1'b1) begin errors++; $display("FAIL rst_sck got=%b want=1", sck); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", frame_done); end
    rst_n = 1'b1;
    cpol = 1'b0;
    settle(3);
  endtask

  task automatic test_write8;
    int exp;
    w_r_mode = 2'b01; wr_width = 6'd8; cpol = 1'b0;
    settle(3);
    cs_sck_en = 1'b1;
    capture(200, 1'b1, 1'b1);
    checks++;
    if (fall_t !== 1) begin errors++; $display("FAIL wr8_fall got=%0d want=1", fall_t); end
    checks++;
    if (busy_t !== 1) begin errors++; $display("FAIL wr8_busy got=%0d want=1", busy_t); end
    checks++;
    if (nedg !== 16) begin errors++; $display("FAIL wr8_edges got=%0d want=16", nedg); end
    checks++;
    if (sck_e1 !== 1'b1) begin errors++; $display("FAIL wr8_first_rise got=%b want=1", sck_e1); end
    checks++;
    if (et[0] !== 6) begin errors++; $display("FAIL wr8_edge1 got=%0d want=6", et[0]); end
    checks++;
    if (et[15] !== 81) begin errors++; $display("FAIL wr8_edge16 got=%0d want=81", et[15]); end
    checks++;
    if (rise_t !== 86) begin errors++; $display("FAIL wr8_rise got=%0d want=86", rise_t); end
    checks++;
    if (fd_t !== 86) begin errors++; $display("FAIL wr8_done got=%0d want=86", fd_t); end
    checks++;
    if (fd_n !== 1) begin errors++; $display("FAIL wr8_done_cnt got=%0d want=1", fd_n); end
    for (int j = 1; j <= 16 && j <= nedg; j++) begin
      exp = 6 + (j / 2) * 5 + ((j - 1) / 2) * 5;
      checks++;
      if (et[j-1] !== exp) begin
        errors++;
        $display("FAIL wr8_edge_time j=%0d got=%0d want=%0d", j, et[j-1], exp);
      end
    end
    settle(3);
  endtask

  task automatic test_cmd_read;
    w_r_mode = 2'b10; wr_width = 6'd8; rd_width = 6'd16; cpol = 1'b1;
    settle(3);
    cs_sck_en = 1'b1;
    capture(400, 1'b1, 1'b0);
    checks++;
    if (nedg !== 48) begin errors++; $display("FAIL cmd_edges got=%0d want=48", nedg); end
    checks++;
    if (rise_t - fall_t !== 245) begin errors++; $display("FAIL cmd_cs_low got=%0d want=245", rise_t - fall_t); end
    checks++;
    if (sck_at_fall !== 1'b1) begin errors++; $display("FAIL cmd_idle_before got=%b want=1", sck_at_fall); end
    checks++;
    if (sck_at_rise !== 1'b1) begin errors++; $display("FAIL cmd_idle_after got=%b want=1", sck_at_rise); end
    checks++;
    if (et[0] !== 6) begin errors++; $display("FAIL cmd_edge1 got=%0d want=6", et[0]); end
    cpol = 1'b0;
    settle(3);
  endtask

  task automatic test_zero_and_bad;
    w_r_mode = 2'b01; wr_width = 6'd0;
    settle(3);
    cs_sck_en = 1'b1;
    capture(100, 1'b1, 1'b0);
    checks++;
    if (rise_t - fall_t !== 10) begin errors++; $display("FAIL zero_cs_low got=%0d want=10", rise_t - fall_t); end
    checks++;
    if (nedg !== 0) begin errors++; $display("FAIL zero_edges got=%0d want=0", nedg); end
    checks++;
    if (fd_n !== 1) begin errors++; $display("FAIL zero_done got=%0d want=1", fd_n); end
    settle(3);
    w_r_mode = 2'b11; wr_width = 6'd8;
    cs_sck_en = 1'b1;
    capture(40, 1'b1, 1'b0);
    cs_sck_en = 1'b0;
    checks++;
    if (busy_t !== -1) begin errors++; $display("FAIL bad_busy got=%0d want=-1", busy_t); end
    checks++;
    if (fall_t !== -1) begin errors++; $display("FAIL bad_cs got=%0d want=-1", fall_t); end
    settle(3);
  endtask

  task automatic test_widths;
    w_r_mode = 2'b01; wr_width = 6'd40;
    settle(3);
    cs_sck_en = 1'b1;
    capture(500, 1'b1, 1'b0);
    checks++;
    if (nedg !== 64) begin errors++; $display("FAIL clamp_edges got=%0d want=64", nedg); end
    settle(3);
    w_r_mode = 2'b00; wr_width = 6'd20; rd_width = 6'd3;
    cs_sck_en = 1'b1;
    capture(100, 1'b1, 1'b0);
    checks++;
    if (nedg !== 6) begin errors++; $display("FAIL rd3_edges got=%0d want=6", nedg); end
    checks++;
    if (rise_t !== 36) begin errors++; $display("FAIL rd3_rise got=%0d want=36", rise_t); end
    settle(3);
  endtask

  task automatic test_held_request;
    int falls, g;
    logic prev;
    w_r_mode = 2'b01; wr_width = 6'd8;
    settle(3);
    cs_sck_en = 1'b1;
    falls = 0;
    prev = cs;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (prev === 1'b1 && cs === 1'b0) falls++;
      prev = cs;
    end
    checks++;
    if (falls !== 1) begin errors++; $display("FAIL held_frames got=%0d want=1", falls); end
    cs_sck_en = 1'b0;
    g = 0;
    while (busy === 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_release busy=%b want=0", busy); end
    settle(3);
  endtask

  task automatic cs_high_after_frame(output int n, output bit fd_ok);
    int g;
    g = 0;
    cs_sck_en = 1'b1;
    while (frame_done !== 1'b1 && g < 200) begin
      @(negedge clk);
      if (busy === 1'b1) cs_sck_en = 1'b0;
      g++;
    end
    fd_ok = (frame_done === 1'b1);
    cs_sck_en = 1'b0;
    n = 0;
    while (cs === 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) cs_sck_en = 1'b1;
    end
    cs_sck_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    w_r_mode = 2'b01; wr_width = 6'd4;
`ifdef SPI_CS_GAP_EN
    cs_gap = 8'd0;
`endif
    settle(3);
    cs_high_after_frame(n, ok);
    checks++;
    if (!ok || n >= 150) begin errors++; $display("FAIL b2b_restart done=%0d high=%0d", ok, n); end
    checks++;
    if (n < 10) begin errors++; $display("FAIL b2b_gap got=%0d want>=10", n); end
    settle(3);
  endtask

`ifdef SPI_CS_GAP_EN
  task automatic test_cs_gap;
    int n;
    bit ok;
    w_r_mode = 2'b01; wr_width = 6'd4; cs_gap = 8'd20;
    settle(3);
    cs_high_after_frame(n, ok);
    checks++;
    if (!ok || n >= 150) begin errors++; $display("FAIL gap_restart done=%0d high=%0d", ok, n); end
    checks++;
    if (n < 30) begin errors++; $display("FAIL gap_high got=%0d want>=30", n); end
    settle(3);
  endtask
`endif

  task automatic test_reset_mid;
    int g, act;
    logic prev;
    w_r_mode = 2'b01; wr_width = 6'd8; cpol = 1'b0;
    settle(3);
    cs_sck_en = 1'b1;
    g = 0; act = 0;
    prev = sck;
    while (act < 7 && g < 200) begin
      @(negedge clk);
      if (sck !== prev) act++;
      prev = sck;
      g++;
    end
    checks++;
    if (act !== 7 || sck !== 1'b1) begin errors++; $display("FAIL mid_reach edges=%0d sck=%b", act, sck); end
    rst_n = 1'b0;
    cs_sck_en = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b1) begin errors++; $display("FAIL mid_cs got=%b want=1", cs); end
    checks++;
    if (sck !== 1'b0) begin errors++; $display("FAIL mid_sck got=%b want=0", sck); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = 0; g = 0;
    prev = sck;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sck !== prev) act++;
      if (cs !== 1'b1) g++;
      prev = sck;
    end
    checks++;
    if (act !== 0) begin errors++; $display("FAIL mid_after_sck got=%0d want=0", act); end
    checks++;
    if (g !== 0) begin errors++; $display("FAIL mid_after_cs got=%0d want=0", g); end
  endtask

  initial begin
    test_reset;
    test_write8;
    test_cmd_read;
    test_zero_and_bad;
    test_widths;
    test_held_request;
    test_back_to_back;
`ifdef SPI_CS_GAP_EN
    test_cs_gap;
`endif
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
